// File: rtl/traffic_pkg.sv
// Shared definitions for the vehicle-sensor front end and the controller that
// decodes sensor_combo.
package traffic_pkg;
  typedef enum logic [1:0] {ST_LO, CHK_HI, ST_HI, CHK_LO} deb_state_t;

  localparam int SENSOR_A_BIT = 1;
  localparam int SENSOR_B_BIT = 0;
  localparam int NUM_CH       = 4;
endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: a 2-flop synchroniser feeding a 4-state debounce FSM.
// The debounced level changes only after the synchronised input has held a new value long enough.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_50M,
  input  logic reset_btn,
  input  logic raw,
  output logic deb
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic          s;
  deb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          done;

  always_ff @(posedge clk_50M or negedge reset_btn) begin
    if (!reset_btn) begin
      sync  <= '0;
      state <= ST_LO;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign s       = sync[1];
  assign cnt_inc = cnt + CW'(1);
  // The entry cycle counts as the first stable cycle, so the switch happens
  // once the incremented count reaches DEB_CYCLES-1.
  assign done    = (cnt_inc == CW'(DEB_CYCLES - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_LO:  if (s) begin state_n = CHK_HI; cnt_n = '0; end
      CHK_HI: if (!s)       state_n = ST_LO;
              else if (done) state_n = ST_HI;
              else           cnt_n   = cnt_inc;
      ST_HI:  if (!s) begin state_n = CHK_LO; cnt_n = '0; end
      CHK_LO: if (s)        state_n = ST_HI;
              else if (done) state_n = ST_LO;
              else           cnt_n   = cnt_inc;
      default: state_n = ST_LO;
    endcase
  end

  assign deb = (state == ST_HI) || (state == CHK_LO);
endmodule

// File: rtl/traffic_sensor_frontend.sv
// Receive side of the vehicle-sensor interface: debounced presence, latched
// per-road service requests and saturating arrival counters.
module traffic_sensor_frontend
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 8
) (
  input  logic             clk_50M,
  input  logic             reset_btn,
  input  logic             AS1,
  input  logic             AS2,
  input  logic             BS1,
  input  logic             BS2,
  input  logic             serve_a,
  input  logic             serve_b,
  input  logic             cnt_clr,
  output logic             a_present,
  output logic             b_present,
  output logic [1:0]       sensor_combo,
  output logic [CNT_W-1:0] a_arrivals,
  output logic [CNT_W-1:0] b_arrivals
);
  logic [NUM_CH-1:0] raw, deb;
  logic              a_req, b_req, a_prev, b_prev;

  assign raw = {BS2, BS1, AS2, AS1};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_50M   (clk_50M),
      .reset_btn (reset_btn),
      .raw       (raw[i]),
      .deb       (deb[i])
    );
  end

  always_ff @(posedge clk_50M or negedge reset_btn) begin
    if (!reset_btn) begin
      a_present  <= 1'b0;
      b_present  <= 1'b0;
      a_prev     <= 1'b0;
      b_prev     <= 1'b0;
      a_req      <= 1'b0;
      b_req      <= 1'b0;
      a_arrivals <= '0;
      b_arrivals <= '0;
    end else begin
      a_present <= deb[0] | deb[1];
      b_present <= deb[2] | deb[3];
      a_prev    <= a_present;
      b_prev    <= b_present;
      // Presence in the same cycle as serve re-arms the request.
      a_req     <= a_present | (a_req & ~serve_a);
      b_req     <= b_present | (b_req & ~serve_b);
      if (cnt_clr)
        a_arrivals <= '0;
      else if (a_present && !a_prev && (a_arrivals != '1))
        a_arrivals <= a_arrivals + CNT_W'(1);
      if (cnt_clr)
        b_arrivals <= '0;
      else if (b_present && !b_prev && (b_arrivals != '1))
        b_arrivals <= b_arrivals + CNT_W'(1);
    end
  end

  assign sensor_combo[SENSOR_A_BIT] = a_req;
  assign sensor_combo[SENSOR_B_BIT] = b_req;
endmodule
